// File: rtl/wb_regfile.sv
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back stage register file: 32x32 GPRs with same-cycle
//            write-to-read bypass, commit trace, retire counter, Tnew check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter logic [31:0] BUBBLE_PC = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_data,
  input  logic [4:0]       wb_addr,
  input  logic [2:0]       wb_tnew,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [31:0]      rs_data,
  output logic [31:0]      rt_data,
  output logic             trace_valid,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_addr,
  output logic [31:0]      trace_data,
  output logic [CNT_W-1:0] retired,
  output logic             tnew_err
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_regs [0:31];
  logic             r_trace_valid;
  logic [31:0]      r_trace_pc;
  logic [4:0]       r_trace_addr;
  logic [31:0]      r_trace_data;
  logic [CNT_W-1:0] r_retired;
  logic             r_tnew_err;
  logic             w_we;

  assign w_we = (wb_addr != 5'd0) && !reset;

  // Register 0 is never written (w_we excludes it), so it stays at its reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_addr  <= '0;
      r_trace_data  <= '0;
      r_retired     <= '0;
      r_tnew_err    <= 1'b0;
    end else begin
      r_trace_valid <= w_we;
      if (w_we) begin
        r_trace_pc   <= wb_pc;
        r_trace_addr <= wb_addr;
        r_trace_data <= wb_data;
      end
      if (wb_pc != BUBBLE_PC) begin
        r_retired <= r_retired + c_cnt_one;
      end
      if (w_we && (wb_tnew != 3'd0)) begin
        r_tnew_err <= 1'b1;
      end
    end
  end

  // Write-before-read: a decode read of the register being committed sees the new value.
  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == 5'd0) begin
      rs_data = '0;
    end else if (w_we && (rs_addr == wb_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == 5'd0) begin
      rt_data = '0;
    end else if (w_we && (rt_addr == wb_addr)) begin
      rt_data = wb_data;
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_addr  = r_trace_addr;
  assign trace_data  = r_trace_data;
  assign retired     = r_retired;
  assign tnew_err    = r_tnew_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed self-checking bench for wb_regfile (32-bit and 4-bit
//            retire counter instances driven from the same slot stream).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_pc;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [2:0]  wb_tnew;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;

  logic [31:0] rs_data, rt_data, trace_pc, trace_data, retired;
  logic        trace_valid, tnew_err;
  logic [4:0]  trace_addr;

  logic [31:0] n_rs_data, n_rt_data, n_trace_pc, n_trace_data;
  logic        n_trace_valid, n_tnew_err;
  logic [4:0]  n_trace_addr;
  logic [3:0]  n_retired;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BUBBLE_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_tnew(wb_tnew), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .retired(retired), .tnew_err(tnew_err)
  );

  wb_regfile #(.BUBBLE_PC(32'h0000_0000), .CNT_W(4)) dut_narrow (
    .clk(clk), .reset(reset), .wb_pc(wb_pc), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_tnew(wb_tnew), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(n_rs_data), .rt_data(n_rt_data), .trace_valid(n_trace_valid),
    .trace_pc(n_trace_pc), .trace_addr(n_trace_addr), .trace_data(n_trace_data),
    .retired(n_retired), .tnew_err(n_tnew_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [31:0] pc, input logic [4:0] addr,
                      input logic [31:0] data, input logic [2:0] tnew);
    wb_pc   = pc;
    wb_addr = addr;
    wb_data = data;
    wb_tnew = tnew;
  endtask

  task automatic do_reset();
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    step();
    step();
    reset = 1'b0;

    // Reset: write reg5, then reset with a write to reg6 presented (discarded)
    slot(32'h1000, 5'd5, 32'hDEAD_BEEF, 3'd0);
    step();
    check("pre_reset_trace_valid", {31'b0, trace_valid}, 32'h1);
    slot(32'h1004, 5'd6, 32'h0000_0055, 3'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    rs_addr = 5'd5;
    rt_addr = 5'd6;
    #1;
    check("reset_reg5", rs_data, 32'h0);
    check("reset_reg6_discarded", rt_data, 32'h0);
    check("reset_retired", retired, 32'h0);
    check("reset_trace_valid", {31'b0, trace_valid}, 32'h0);
    check("reset_trace_pc", trace_pc, 32'h0);
    check("reset_tnew_err", {31'b0, tnew_err}, 32'h0);

    // Bypass on both ports
    slot(32'h2000, 5'd8, 32'h1234_5678, 3'd0);
    rs_addr = 5'd8;
    rt_addr = 5'd8;
    #1;
    check("bypass_rs", rs_data, 32'h1234_5678);
    check("bypass_rt", rt_data, 32'h1234_5678);
    step();
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    #1;
    check("reg8_after_edge", rs_data, 32'h1234_5678);
    check("bypass_trace_valid", {31'b0, trace_valid}, 32'h1);
    check("bypass_trace_pc", trace_pc, 32'h2000);
    check("bypass_trace_addr", {27'b0, trace_addr}, 32'd8);
    check("bypass_trace_data", trace_data, 32'h1234_5678);
    check("bypass_retired", retired, 32'd1);

    // Mixed: rs reads committed reg8, rt bypasses a new write to reg9
    slot(32'h2004, 5'd9, 32'hCAFE_0009, 3'd0);
    rt_addr = 5'd9;
    #1;
    check("mixed_rs_reg", rs_data, 32'h1234_5678);
    check("mixed_rt_bypass", rt_data, 32'hCAFE_0009);
    step();

    // $0 write: ignored and not traced, but the instruction retires
    slot(32'h3000, 5'd0, 32'hFFFF_FFFF, 3'd0);
    rs_addr = 5'd0;
    #1;
    check("zero_rs_during", rs_data, 32'h0);
    step();
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    #1;
    check("zero_rs_after", rs_data, 32'h0);
    check("zero_trace_valid", {31'b0, trace_valid}, 32'h0);
    check("zero_trace_hold_pc", trace_pc, 32'h2004);
    check("zero_retired", retired, 32'd3);

    // Bubble sequence: writes, a store, two bubbles, a write
    do_reset();
    slot(32'h3000, 5'd1, 32'h0000_0011, 3'd0); step();
    check("seq0_tv", {31'b0, trace_valid}, 32'h1);
    slot(32'h3004, 5'd0, 32'h0000_0022, 3'd0); step();
    check("seq1_tv", {31'b0, trace_valid}, 32'h0);
    slot(32'h3008, 5'd2, 32'h0000_0033, 3'd0); step();
    check("seq2_tv", {31'b0, trace_valid}, 32'h1);
    check("seq2_tpc", trace_pc, 32'h3008);
    slot(32'h0, 5'd0, 32'h0, 3'd0); step();
    check("seq3_tv", {31'b0, trace_valid}, 32'h0);
    step();
    check("seq4_tv", {31'b0, trace_valid}, 32'h0);
    check("seq4_retired", retired, 32'd3);
    slot(32'h300C, 5'd4, 32'h0000_0044, 3'd0); step();
    check("seq5_tv", {31'b0, trace_valid}, 32'h1);
    check("seq5_taddr", {27'b0, trace_addr}, 32'd4);
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    #1;
    check("seq_retired", retired, 32'd4);

    // Tnew violation: write still commits, flag is sticky until reset
    do_reset();
    slot(32'h4000, 5'd3, 32'h0000_0007, 3'd1);
    step();
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    rs_addr = 5'd3;
    #1;
    check("tnew_reg3", rs_data, 32'h7);
    check("tnew_err_set", {31'b0, tnew_err}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      slot(32'h4004 + 32'(i * 4), 5'(10 + i), 32'(i), 3'd0);
      step();
    end
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    #1;
    check("tnew_err_sticky", {31'b0, tnew_err}, 32'h1);
    check("tnew_retired", retired, 32'd11);
    do_reset();
    #1;
    check("tnew_err_cleared", {31'b0, tnew_err}, 32'h0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      slot(32'h5000 + 32'(i * 4), 5'd0, 32'h0, 3'd0);
      step();
    end
    check("wrap16_narrow", {28'b0, n_retired}, 32'd0);
    check("wrap16_wide", retired, 32'd16);
    slot(32'h5040, 5'd0, 32'h0, 3'd0);
    step();
    slot(32'h0, 5'd0, 32'h0, 3'd0);
    #1;
    check("wrap17_narrow", {28'b0, n_retired}, 32'd1);
    check("wrap17_wide", retired, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM→WB pipeline register: consumes the registered PC, write data, destination register number and Tnew.
- Commits results into the 32×32 general register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Produces a registered commit trace, for the testbench and debug, and a retired-instruction counter.
- Flags a protocol violation if a write arrives with nonzero Tnew.

Parameters:
- BUBBLE_PC, 32'h0000_0000, PC value that marks a flushed/bubble slot (never retired, never traced)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- wb_pc  input  32  PC of the instruction in WB
- wb_data  input  32  result to write
- wb_addr  input  5  destination register; 0 = no write
- wb_tnew  input  3  Tnew of the instruction in WB; must be 0
- rs_addr  input  5  read port A address (decode stage)
- rt_addr  input  5  read port B address (decode stage)
- rs_data  output  32  read port A data
- rt_data  output  32  read port B data
- trace_valid  output  1  one-cycle pulse: a register write committed last cycle
- trace_pc  output  32  PC of the traced write
- trace_addr  output  5  register written
- trace_data  output  32  value written
- retired  output  CNT_W  count of non-bubble instructions that passed WB
- tnew_err  output  1  sticky: a write was presented with wb_tnew != 0

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - All 32 registers := 0.
  - trace_valid/trace_pc/trace_addr/trace_data := 0.
  - retired := 0; tnew_err := 0.
  - Any write presented in the same cycle is discarded.
  - Reset has priority over every other event.
- Write enable: we = (wb_addr != 0) && !reset.
  - On the rising edge with we=1: reg[wb_addr] := wb_data.
  - Register 0 always reads 0; writes to it are ignored and not traced.
- Reads are combinational:
  - rs_data = 0 if rs_addr==0.
  - Else wb_data if we && rs_addr==wb_addr (bypass, write-before-read in the same cycle).
  - Else reg[rs_addr].
  - rt_data is identical, using rt_addr.
  - Both ports may hit the bypass at once.
- Trace, registered with 1-cycle latency:
  - On each edge: trace_valid := we.
  - When we=1: trace_pc := wb_pc, trace_addr := wb_addr, trace_data := wb_data.
  - When we=0: trace_pc/trace_addr/trace_data hold their previous values.
- Retire counter:
  - On each non-reset edge: if wb_pc != BUBBLE_PC then retired := retired + 1 (mod 2^CNT_W).
  - Wraps from all-ones to 0 silently.
  - Non-writing instructions (stores, branches) count.
  - Bubbles (all-zero slot after a pipeline flush) do not count.
- Tnew check: if we=1 and wb_tnew != 0 at an edge, then tnew_err := 1 and stays 1 until reset. The write still commits.
- No backpressure; one slot is consumed every cycle.
- Flush interaction: a flushed slot arrives as all zeros. It causes no write, no trace and no count.

Test Plan:
- Reset:
  - Stimulus: write reg5=32'hDEAD_BEEF, then assert reset 1 cycle.
  - Required: rs_addr=5 reads 0, retired=0, trace_valid=0, tnew_err=0.
- Bypass:
  - Stimulus: wb_addr=8, wb_data=32'h1234_5678, rs_addr=rt_addr=8 in the same cycle.
  - Required: rs_data=rt_data=32'h1234_5678 before the edge; after the edge, reg8 holds it and trace_valid=1, trace_pc=wb_pc, trace_addr=8.
- $0 write:
  - Stimulus: wb_addr=0, wb_data=32'hFFFF_FFFF, wb_pc=32'h3000.
  - Required: rs_addr=0 reads 0; trace_valid stays 0; retired increments by 1.
- Bubble sequence:
  - Stimulus: 3 valid PCs (32'h3000, 32'h3004, 32'h3008), 2 all-zero slots, 1 valid PC.
  - Required: retired=4; trace_valid pulses only for the slots with wb_addr!=0.
- Tnew violation:
  - Stimulus: wb_addr=3, wb_tnew=1, wb_data=7.
  - Required: reg3=7 and tnew_err=1; tnew_err remains 1 over 10 clean cycles; a reset clears it.
- Counter wrap:
  - Stimulus: CNT_W=4, 16 valid instructions.
  - Required: retired returns to 0; the 17th instruction gives retired=1.
